// File: rtl/led_pattern_sched.sv
// LED pattern scheduler: steps through one of four fixed LED pattern tables
// at a programmable rate. Mode changes made while running are held until the
// sequence wraps, so a pattern is never cut off partway through.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | after reset; LEDs dark, mode_req writes mode_cur directly
// RUN    | run=1, counting cycles and stepping through the pattern
// PAUSE  | run dropped; cnt, idx and led frozen until run returns
module led_pattern_sched #(
    parameter logic [23:0] DIV_RESET = 24'd6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        mode_req,
    input  logic [1:0]  mode_sel,
    input  logic        div_we,
    input  logic [23:0] div_val,
    output logic [7:0]  led,
    output logic [1:0]  mode_cur,
    output logic        step_tick,
    output logic        seq_wrap
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [23:0] cnt_q, cnt_d;
    logic [23:0] div_q, div_d;
    logic [7:0]  led_q, led_d;
    logic [1:0]  mode_q, mode_d;
    logic [1:0]  pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic        tick_q, tick_d;
    logic        wrap_q, wrap_d;

    logic        step_due;
    logic        last_step;
    logic        step_go;
    logic        restart;
    logic [1:0]  new_mode;

    // Fixed pattern tables, indexed by {mode, step}.
    function automatic logic [7:0] pat(input logic [1:0] m, input logic [3:0] i);
        logic [7:0] p;
        p = 8'h00;
        case ({m, i})
            {2'd0, 4'd0}:  p = 8'h80;
            {2'd0, 4'd1}:  p = 8'h40;
            {2'd0, 4'd2}:  p = 8'h20;
            {2'd0, 4'd3}:  p = 8'h10;
            {2'd0, 4'd4}:  p = 8'h08;
            {2'd0, 4'd5}:  p = 8'h04;
            {2'd0, 4'd6}:  p = 8'h02;
            {2'd0, 4'd7}:  p = 8'h01;
            {2'd1, 4'd0}:  p = 8'h80;
            {2'd1, 4'd1}:  p = 8'h40;
            {2'd1, 4'd2}:  p = 8'h20;
            {2'd1, 4'd3}:  p = 8'h10;
            {2'd1, 4'd4}:  p = 8'h08;
            {2'd1, 4'd5}:  p = 8'h04;
            {2'd1, 4'd6}:  p = 8'h02;
            {2'd1, 4'd7}:  p = 8'h01;
            {2'd1, 4'd8}:  p = 8'h02;
            {2'd1, 4'd9}:  p = 8'h04;
            {2'd1, 4'd10}: p = 8'h08;
            {2'd1, 4'd11}: p = 8'h10;
            {2'd1, 4'd12}: p = 8'h20;
            {2'd1, 4'd13}: p = 8'h40;
            {2'd2, 4'd0}:  p = 8'h81;
            {2'd2, 4'd1}:  p = 8'h42;
            {2'd2, 4'd2}:  p = 8'h24;
            {2'd2, 4'd3}:  p = 8'h18;
            {2'd2, 4'd4}:  p = 8'h24;
            {2'd2, 4'd5}:  p = 8'h42;
            {2'd3, 4'd0}:  p = 8'hFF;
            {2'd3, 4'd1}:  p = 8'h00;
            default:       p = 8'h00;
        endcase
        return p;
    endfunction

    // Index of the final step of each pattern.
    function automatic logic [3:0] last_idx(input logic [1:0] m);
        logic [3:0] l;
        case (m)
            2'd0:    l = 4'd7;
            2'd1:    l = 4'd13;
            2'd2:    l = 4'd5;
            default: l = 4'd1;
        endcase
        return l;
    endfunction

    // Next-state logic for the sequencer, step counter and mode handling.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        led_d      = led_q;
        mode_d     = mode_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        tick_d     = 1'b0;
        wrap_d     = 1'b0;

        step_due  = run && (state_q != S_IDLE) && (cnt_q == div_q);
        last_step = (idx_q == last_idx(mode_q));
        step_go   = step_due && !div_we;
        // A divisor write swallows the step, but a mode request landing on
        // the wrap edge still takes effect: the sequence restarts silently
        // at step 0 of the new mode.
        restart   = step_due && div_we && last_step && mode_req;
        new_mode  = mode_req ? mode_sel : (pend_vld_q ? pend_q : mode_q);

        case (state_q)
            S_IDLE: begin
                pend_vld_d = 1'b0;
                if (mode_req) begin
                    mode_d = mode_sel;
                end
                if (run) begin
                    state_d = S_RUN;
                    idx_d   = 4'd0;
                    cnt_d   = 24'd0;
                    led_d   = pat(mode_req ? mode_sel : mode_q, 4'd0);
                end
            end
            S_RUN, S_PAUSE: begin
                if (mode_req) begin
                    pend_d     = mode_sel;
                    pend_vld_d = 1'b1;
                end
                if (!run) begin
                    state_d = S_PAUSE;
                end else begin
                    state_d = S_RUN;
                    cnt_d   = step_due ? 24'd0 : cnt_q + 24'd1;
                    if (step_go && !last_step) begin
                        idx_d  = idx_q + 4'd1;
                        led_d  = pat(mode_q, idx_q + 4'd1);
                        tick_d = 1'b1;
                    end else if ((step_go && last_step) || restart) begin
                        mode_d     = new_mode;
                        pend_vld_d = 1'b0;
                        idx_d      = 4'd0;
                        led_d      = pat(new_mode, 4'd0);
                        tick_d     = step_go;
                        wrap_d     = step_go;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (div_we) begin
            div_d = div_val;
            cnt_d = 24'd0;
        end
    end

    // State and registered outputs; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            idx_q      <= 4'd0;
            cnt_q      <= 24'd0;
            div_q      <= DIV_RESET;
            led_q      <= 8'h00;
            mode_q     <= 2'd0;
            pend_q     <= 2'd0;
            pend_vld_q <= 1'b0;
            tick_q     <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            led_q      <= led_d;
            mode_q     <= mode_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            tick_q     <= tick_d;
            wrap_q     <= wrap_d;
        end
    end

    assign led       = led_q;
    assign mode_cur  = mode_q;
    assign step_tick = tick_q;
    assign seq_wrap  = wrap_q;

endmodule
